// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
// Shared encodings and defaults for the AHB slave side of the AHB-to-APB
// bridge: HTRANS/HBURST/HRESP codes, the burst-tracking FSM state type,
// the error-response state type and the default APB window placement.
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
   localparam logic [31:0] DEF_REGION_SZ = 32'h0400_0000;

   typedef enum logic {
      B_IDLE   = 1'b0,
      B_ACTIVE = 1'b1
   } burst_state_t;

   typedef enum logic [1:0] {
      E_OKAY = 2'b00,
      E_ERR1 = 2'b01,
      E_ERR2 = 2'b10
   } err_state_t;

   // Beat count of a fixed-length burst; 0 for SINGLE and unbounded INCR.
   function automatic logic [4:0] burst_len(input logic [2:0] hburst);
      logic [4:0] len;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
         default:                      len = 5'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// ---------------------------------------------------------------------------
// ahb_addr_decoder
// Combinational window check and one-hot slave select for the three
// consecutive APB regions starting at BASE_ADDR, each REGION_SZ bytes.
//
// Ports:
//   haddr     in  32  AHB address
//   in_window out  1  haddr lies in [BASE_ADDR, BASE_ADDR+3*REGION_SZ)
//   tempsel   out  3  one-hot region select, 3'b000 outside the window
// ---------------------------------------------------------------------------
module ahb_addr_decoder
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter logic [31:0] REGION_SZ = DEF_REGION_SZ
) (
   input  logic [31:0] haddr,
   output logic        in_window,
   output logic [2:0]  tempsel
);

   // Limits are carried in 34 bits so a window touching the top of the
   // 4 GB space cannot wrap around and alias low addresses.
   localparam logic [33:0] LIM0 = {2'b00, BASE_ADDR};
   localparam logic [33:0] LIM1 = LIM0 + {2'b00, REGION_SZ};
   localparam logic [33:0] LIM2 = LIM1 + {2'b00, REGION_SZ};
   localparam logic [33:0] LIM3 = LIM2 + {2'b00, REGION_SZ};

   logic [33:0] addr_ext;

   assign addr_ext = {2'b00, haddr};

   always_comb begin
      tempsel = 3'b000;
      if (addr_ext < LIM0) begin
         tempsel = 3'b000;
      end else if (addr_ext < LIM1) begin
         tempsel = 3'b001;
      end else if (addr_ext < LIM2) begin
         tempsel = 3'b010;
      end else if (addr_ext < LIM3) begin
         tempsel = 3'b100;
      end
   end

   assign in_window = |tempsel;

endmodule

// File: rtl/ahb_slave_interface.sv
// ---------------------------------------------------------------------------
// ahb_slave_interface
// AHB slave front end of the AHB-to-APB bridge. Qualifies transfers into
// the APB window, pipelines address/data for the APB FSM controller and
// tracks burst progress.
//
// Optional feature macro: AHB_ERR_RESP_EN
//   defined   : out-of-window NONSEQ/SEQ gets a two-cycle ERROR response
//               and aborts any active burst
//   undefined : hresp fixed OKAY, err_hready fixed 1, such transfers dropped
//
// Ports:
//   clk, hresetn                 clock, async active-low reset
//   hwrite, hreadyin, htrans,
//   hburst, hsize, haddr, hwdata AHB master address/data phase
//   valid                        qualified transfer request (combinational)
//   haddr1/haddr2, hwdata1/2     one-/two-stage pipelined address and data
//   hwritereg                    registered hwrite
//   tempsel                      one-hot slave select (combinational)
//   beat_cnt, burst_last         current burst beat, final fixed-burst beat
//   hresp, err_hready            response to the master
//
// Burst FSM:
//   state    | meaning
//   B_IDLE   | no burst in progress, beat_cnt held at 0
//   B_ACTIVE | burst accepted, beat_cnt indexes the last accepted beat
//
// Error FSM (AHB_ERR_RESP_EN only):
//   state    | meaning
//   E_OKAY   | OKAY response
//   E_ERR1   | ERROR first cycle, err_hready low
//   E_ERR2   | ERROR second cycle, err_hready high
// ---------------------------------------------------------------------------
module ahb_slave_interface
   import ahb_apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter logic [31:0] REGION_SZ = DEF_REGION_SZ
) (
   input  logic        clk,
   input  logic        hresetn,
   input  logic        hwrite,
   input  logic        hreadyin,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hburst,
   input  logic [2:0]  hsize,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   output logic        valid,
   output logic [31:0] haddr1,
   output logic [31:0] haddr2,
   output logic [31:0] hwdata1,
   output logic [31:0] hwdata2,
   output logic        hwritereg,
   output logic [2:0]  tempsel,
   output logic [3:0]  beat_cnt,
   output logic        burst_last,
   output logic [1:0]  hresp,
   output logic        err_hready
);

   logic         in_window;
   logic         is_xfer;
   logic         err_abort;
   logic         unused_hsize;

   burst_state_t bstate, bstate_nxt;
   logic [3:0]   beat_nxt;
   logic [4:0]   blen, blen_nxt;
   logic         unbounded, unbounded_nxt;

   // Transfer size does not affect decode or sequencing here; the APB
   // side always moves a full word.
   assign unused_hsize = ^hsize;

   ahb_addr_decoder #(
      .BASE_ADDR (BASE_ADDR),
      .REGION_SZ (REGION_SZ)
   ) u_addr_decoder (
      .haddr     (haddr),
      .in_window (in_window),
      .tempsel   (tempsel)
   );

   assign is_xfer = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   assign valid   = hreadyin & is_xfer & in_window;

   // Address/data pipeline
   always_ff @(posedge clk or negedge hresetn) begin
      if (!hresetn) begin
         haddr1    <= '0;
         haddr2    <= '0;
         hwdata1   <= '0;
         hwdata2   <= '0;
         hwritereg <= 1'b0;
      end else if (hreadyin) begin
         haddr1    <= haddr;
         haddr2    <= haddr1;
         hwdata1   <= hwdata;
         hwdata2   <= hwdata1;
         hwritereg <= hwrite;
      end
   end

   // Burst tracking
   always_ff @(posedge clk or negedge hresetn) begin
      if (!hresetn) begin
         bstate    <= B_IDLE;
         beat_cnt  <= '0;
         blen      <= '0;
         unbounded <= 1'b0;
      end else begin
         bstate    <= bstate_nxt;
         beat_cnt  <= beat_nxt;
         blen      <= blen_nxt;
         unbounded <= unbounded_nxt;
      end
   end

   assign burst_last = (bstate == B_ACTIVE) && !unbounded &&
                       ({1'b0, beat_cnt} == (blen - 5'd1));

   always_comb begin
      bstate_nxt    = bstate;
      beat_nxt      = beat_cnt;
      blen_nxt      = blen;
      unbounded_nxt = unbounded;
      if (hreadyin) begin
         if (err_abort) begin
            bstate_nxt = B_IDLE;
            beat_nxt   = '0;
         end else if (valid && (htrans == HTRANS_NONSEQ)) begin
            // A new NONSEQ always restarts, even mid-burst.
            beat_nxt = '0;
            if (hburst == HBURST_SINGLE) begin
               bstate_nxt = B_IDLE;
            end else begin
               bstate_nxt    = B_ACTIVE;
               blen_nxt      = burst_len(hburst);
               unbounded_nxt = (hburst == HBURST_INCR);
            end
         end else if (bstate == B_ACTIVE) begin
            case (htrans)
               HTRANS_IDLE: begin
                  bstate_nxt = B_IDLE;
                  beat_nxt   = '0;
               end
               HTRANS_BUSY: begin
                  beat_nxt = beat_cnt;
               end
               default: begin
                  // Anything presented after the final beat closes the burst.
                  if (burst_last) begin
                     bstate_nxt = B_IDLE;
                     beat_nxt   = '0;
                  end else if (valid) begin
                     beat_nxt = (beat_cnt == 4'hF) ? beat_cnt : beat_cnt + 4'd1;
                  end
               end
            endcase
         end
      end
   end

`ifdef AHB_ERR_RESP_EN
   err_state_t estate, estate_nxt;

   assign err_abort = hreadyin & is_xfer & ~in_window;

   always_ff @(posedge clk or negedge hresetn) begin
      if (!hresetn) begin
         estate <= E_OKAY;
      end else begin
         estate <= estate_nxt;
      end
   end

   always_comb begin
      estate_nxt = E_OKAY;
      hresp      = HRESP_OKAY;
      err_hready = 1'b1;
      case (estate)
         E_OKAY: begin
            if (err_abort) estate_nxt = E_ERR1;
         end
         E_ERR1: begin
            hresp      = HRESP_ERROR;
            err_hready = 1'b0;
            estate_nxt = E_ERR2;
         end
         E_ERR2: begin
            hresp = HRESP_ERROR;
            // The master may issue its next transfer here; a bad one
            // starts a fresh error response back to back.
            if (err_abort) estate_nxt = E_ERR1;
         end
         default: begin
            estate_nxt = E_OKAY;
         end
      endcase
   end
`else
   assign err_abort  = 1'b0;
   assign hresp      = HRESP_OKAY;
   assign err_hready = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
module tb_ahb_slave_interface;

   localparam longint BASE = 64'h8000_0000;
   localparam longint RSZ  = 64'h0400_0000;

   logic        clk;
   logic        hresetn;
   logic        hwrite, hreadyin;
   logic [1:0]  htrans;
   logic [2:0]  hburst, hsize;
   logic [31:0] haddr, hwdata;
   logic        valid;
   logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
   logic        hwritereg;
   logic [2:0]  tempsel;
   logic [3:0]  beat_cnt;
   logic        burst_last;
   logic [1:0]  hresp;
   logic        err_hready;

   int asserts = 0;
   int fails   = 0;

   ahb_slave_interface dut (
      .clk        (clk),
      .hresetn    (hresetn),
      .hwrite     (hwrite),
      .hreadyin   (hreadyin),
      .htrans     (htrans),
      .hburst     (hburst),
      .hsize      (hsize),
      .haddr      (haddr),
      .hwdata     (hwdata),
      .valid      (valid),
      .haddr1     (haddr1),
      .haddr2     (haddr2),
      .hwdata1    (hwdata1),
      .hwdata2    (hwdata2),
      .hwritereg  (hwritereg),
      .tempsel    (tempsel),
      .beat_cnt   (beat_cnt),
      .burst_last (burst_last),
      .hresp      (hresp),
      .err_hready (err_hready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit in_win(input logic [31:0] a);
      longint la;
      la = longint'(a);
      return (la >= BASE) && (la < BASE + 3 * RSZ);
   endfunction

   function automatic logic [2:0] sel_of(input logic [31:0] a);
      longint la;
      int     r;
      la = longint'(a);
      if (!in_win(a)) return 3'b000;
      r = int'((la - BASE) / RSZ);
      return 3'(1 << r);
   endfunction

   function automatic int len_of(input logic [2:0] b);
      case (b)
         3'b010, 3'b011: return 4;
         3'b100, 3'b101: return 8;
         3'b110, 3'b111: return 16;
         default:        return 0;
      endcase
   endfunction

   logic [31:0] m_a1 = 0, m_a2 = 0, m_d1 = 0, m_d2 = 0;
   logic        m_wr = 0;
   bit          m_active = 0;
   int          m_beats = 0;   // beats accepted in the current burst, NONSEQ included
   int          m_len = 0;     // 0 = unbounded
   int          m_err = 0;     // error response cycle number, 0 = none
   bit          m_xfer, m_inw, m_last, m_abort;

   function automatic bit model_last();
      return m_active && (m_len != 0) && (m_beats == m_len);
   endfunction

   function automatic int model_beat();
      if (!m_active) return 0;
      return (m_beats - 1 > 15) ? 15 : m_beats - 1;
   endfunction

   always @(posedge clk or negedge hresetn) begin
      if (!hresetn) begin
         m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_wr = 0;
         m_active = 0; m_beats = 0; m_len = 0; m_err = 0;
      end else begin
         m_xfer = htrans[1];
         m_inw  = in_win(haddr);
         m_last = model_last();
`ifdef AHB_ERR_RESP_EN
         m_abort = hreadyin && m_xfer && !m_inw;
         if (m_err == 1)   m_err = 2;
         else if (m_abort) m_err = 1;
         else              m_err = 0;
`else
         m_abort = 0;
`endif
         if (hreadyin) begin
            m_a2 = m_a1; m_a1 = haddr;
            m_d2 = m_d1; m_d1 = hwdata;
            m_wr = hwrite;
            if (m_abort) begin
               m_active = 0; m_beats = 0;
            end else if (htrans == 2'b10 && m_inw) begin
               m_len    = len_of(hburst);
               m_active = (hburst != 3'b000);
               m_beats  = m_active ? 1 : 0;
            end else if (m_active) begin
               if (htrans == 2'b00)          begin m_active = 0; m_beats = 0; end
               else if (m_xfer && m_last)    begin m_active = 0; m_beats = 0; end
               else if (htrans == 2'b11 && m_inw) m_beats++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("valid",      valid,      hreadyin && htrans[1] && in_win(haddr));
      chk("tempsel",    tempsel,    sel_of(haddr));
      chk("haddr1",     haddr1,     m_a1);
      chk("haddr2",     haddr2,     m_a2);
      chk("hwdata1",    hwdata1,    m_d1);
      chk("hwdata2",    hwdata2,    m_d2);
      chk("hwritereg",  hwritereg,  m_wr);
      chk("beat_cnt",   beat_cnt,   model_beat());
      chk("burst_last", burst_last, model_last());
`ifdef AHB_ERR_RESP_EN
      chk("hresp",      hresp,      (m_err != 0) ? 2'b01 : 2'b00);
      chk("err_hready", err_hready, m_err != 1);
`else
      chk("hresp",      hresp,      2'b00);
      chk("err_hready", err_hready, 1'b1);
`endif
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] a,
                        input logic wr, input logic [31:0] d, input logic rdy);
      htrans = tr; hburst = bu; haddr = a; hwrite = wr; hwdata = d; hreadyin = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_in();
      longint r;
      r = BASE + RSZ * longint'($urandom_range(0, 2)) + (longint'($urandom) % RSZ);
      return r[31:0];
   endfunction

   function automatic logic [31:0] rand_out();
      if ($urandom_range(0, 1) == 0) return {1'b0, 31'($urandom)};
      return 32'h8C00_0000 + $urandom_range(0, 32'h73FF_FFFF);
   endfunction

   initial begin
      logic [1:0]  tr;
      logic [31:0] a;
      int          r;

      hresetn = 1'b0;
      hsize   = 3'b010;
      drive(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 1'b1);
      tick(); tick();
      chk("rst_haddr1",     haddr1,     32'h0);
      chk("rst_hwdata2",    hwdata2,    32'h0);
      chk("rst_beat_cnt",   beat_cnt,   4'd0);
      chk("rst_burst_last", burst_last, 1'b0);
      chk("rst_hresp",      hresp,      2'b00);
      chk("rst_err_hready", err_hready, 1'b1);
      hresetn = 1'b1;
      tick();

      // single write
      drive(2'b10, 3'b000, 32'h8000_0010, 1'b1, 32'hA5A5_0001, 1'b1);
      chk("single_valid",   valid,   1'b1);
      chk("single_tempsel", tempsel, 3'b001);
      tick();
      drive(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("single_haddr1",    haddr1,    32'h8000_0010);
      chk("single_hwritereg", hwritereg, 1'b1);
      chk("single_hwdata1",   hwdata1,   32'hA5A5_0001);
      tick();
      chk("single_haddr2",  haddr2,  32'h8000_0010);
      chk("single_hwdata2", hwdata2, 32'hA5A5_0001);

      // INCR4 read in region 1
      drive(2'b10, 3'b011, 32'h8400_0000, 1'b0, 32'h0, 1'b1);
      chk("incr4_tempsel", tempsel, 3'b010);
      tick();
      chk("incr4_beat0", beat_cnt, 4'd0);
      for (int i = 1; i <= 3; i++) begin
         chk("incr4_last_pre", burst_last, 1'b0);
         drive(2'b11, 3'b011, 32'h8400_0000 + 32'(4 * i), 1'b0, 32'h0, 1'b1);
         tick();
         chk("incr4_beat", beat_cnt, 32'(i));
      end
      chk("incr4_last", burst_last, 1'b1);
      drive(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
      chk("incr4_idle_beat", beat_cnt,   4'd0);
      chk("incr4_idle_last", burst_last, 1'b0);

      // INCR8 with BUSY after beat 2
      drive(2'b10, 3'b101, 32'h8800_0000, 1'b1, 32'h1, 1'b1);
      tick();
      drive(2'b11, 3'b101, 32'h8800_0004, 1'b1, 32'h2, 1'b1); tick();
      drive(2'b11, 3'b101, 32'h8800_0008, 1'b1, 32'h3, 1'b1); tick();
      chk("incr8_beat2", beat_cnt, 4'd2);
      drive(2'b01, 3'b101, 32'h8800_000C, 1'b1, 32'h4, 1'b1); tick();
      chk("incr8_busy1", beat_cnt, 4'd2);
      tick();
      chk("incr8_busy2", beat_cnt, 4'd2);
      for (int i = 3; i <= 7; i++) begin
         drive(2'b11, 3'b101, 32'h8800_0000 + 32'(4 * i), 1'b1, 32'(i), 1'b1);
         tick();
         if (i == 6) chk("incr8_last_b6", burst_last, 1'b0);
      end
      chk("incr8_beat7", beat_cnt,   4'd7);
      chk("incr8_last",  burst_last, 1'b1);
      drive(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 1'b1); tick();

      // NONSEQ at beat 2 of INCR16, restarting as INCR4
      drive(2'b10, 3'b111, 32'h8000_0100, 1'b0, 32'h0, 1'b1); tick();
      drive(2'b11, 3'b111, 32'h8000_0104, 1'b0, 32'h0, 1'b1); tick();
      drive(2'b11, 3'b111, 32'h8000_0108, 1'b0, 32'h0, 1'b1); tick();
      chk("incr16_beat2", beat_cnt, 4'd2);
      drive(2'b10, 3'b011, 32'h8000_0400, 1'b0, 32'h0, 1'b1); tick();
      chk("restart_beat0", beat_cnt, 4'd0);
      for (int i = 1; i <= 3; i++) begin
         drive(2'b11, 3'b011, 32'h8000_0400 + 32'(4 * i), 1'b0, 32'h0, 1'b1);
         tick();
      end
      chk("restart_beat3", beat_cnt,   4'd3);
      chk("restart_last",  burst_last, 1'b1);
      drive(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 1'b1); tick();

      // unbounded INCR saturates and never flags last
      drive(2'b10, 3'b001, 32'h8800_1000, 1'b0, 32'h0, 1'b1); tick();
      for (int i = 1; i <= 18; i++) begin
         drive(2'b11, 3'b001, 32'h8800_1000 + 32'(4 * i), 1'b0, 32'h0, 1'b1);
         tick();
      end
      chk("incr_sat_beat", beat_cnt,   4'd15);
      chk("incr_sat_last", burst_last, 1'b0);
      drive(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 1'b1); tick();

      // hreadyin low for 3 cycles holds the pipeline
      drive(2'b10, 3'b000, 32'h8000_0A00, 1'b1, 32'h1111_1111, 1'b1); tick();
      drive(2'b10, 3'b000, 32'h8000_0B00, 1'b1, 32'h2222_2222, 1'b1); tick();
      for (int i = 0; i < 3; i++) begin
         drive(2'b10, 3'b000, $urandom, 1'b0, $urandom, 1'b0);
         tick();
         chk("stall_haddr1",  haddr1,  32'h8000_0B00);
         chk("stall_haddr2",  haddr2,  32'h8000_0A00);
         chk("stall_hwdata1", hwdata1, 32'h2222_2222);
         chk("stall_hwdata2", hwdata2, 32'h1111_1111);
      end
      drive(2'b10, 3'b000, 32'h8000_0C00, 1'b0, 32'h3333_3333, 1'b1); tick();
      chk("resume_haddr1", haddr1, 32'h8000_0C00);
      chk("resume_haddr2", haddr2, 32'h8000_0B00);

      // out-of-window NONSEQ
      drive(2'b10, 3'b000, 32'h9000_0000, 1'b0, 32'h0, 1'b1);
      chk("oow_valid",   valid,   1'b0);
      chk("oow_tempsel", tempsel, 3'b000);
      tick();
      drive(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 1'b1);
`ifdef AHB_ERR_RESP_EN
      chk("err1_hresp", hresp, 2'b01); chk("err1_hready", err_hready, 1'b0);
      tick();
      chk("err2_hresp", hresp, 2'b01); chk("err2_hready", err_hready, 1'b1);
      tick();
      chk("err3_hresp", hresp, 2'b00); chk("err3_hready", err_hready, 1'b1);
`else
      chk("noerr1_hresp", hresp, 2'b00); chk("noerr1_hready", err_hready, 1'b1);
      tick();
      chk("noerr2_hresp", hresp, 2'b00);
      tick();
`endif

      // reset mid-burst, then a SEQ must not count
      drive(2'b10, 3'b011, 32'h8800_0000, 1'b1, 32'h5, 1'b1); tick();
      drive(2'b11, 3'b011, 32'h8800_0004, 1'b1, 32'h6, 1'b1); tick();
      chk("pre_rst_beat", beat_cnt, 4'd1);
      hresetn = 1'b0;
      #1;
      chk("midrst_beat",   beat_cnt,   4'd0);
      chk("midrst_last",   burst_last, 1'b0);
      chk("midrst_haddr1", haddr1,     32'h0);
      chk("midrst_wr",     hwritereg,  1'b0);
      tick();
      hresetn = 1'b1;
      drive(2'b11, 3'b011, 32'h8800_0008, 1'b1, 32'h7, 1'b1); tick();
      drive(2'b11, 3'b011, 32'h8800_000C, 1'b1, 32'h8, 1'b1); tick();
      chk("seq_in_idle_beat", beat_cnt,   4'd0);
      chk("seq_in_idle_last", burst_last, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r  = $urandom_range(0, 99);
         tr = (r < 20) ? 2'b00 : (r < 35) ? 2'b01 : (r < 60) ? 2'b10 : 2'b11;
         a  = ($urandom_range(0, 99) < 88) ? rand_in() : rand_out();
         drive(tr, 3'($urandom_range(0, 7)), a, 1'($urandom), $urandom,
               $urandom_range(0, 99) < 85);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
